// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, bypass select encodings, FSM states and pipeline slot layouts
// for the hazard/forwarding controller.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 6;

  localparam logic [1:0] BYP_DX = 2'b00;
  localparam logic [1:0] BYP_XM = 2'b01;
  localparam logic [1:0] BYP_MW = 2'b10;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
    logic             md;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_rd;
    logic             rs2_rd;
  } dx_t;

  // No load flag past X: nothing downstream of the D/X slot consumes it.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
  } xm_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
  } mw_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage fields, multdiv handshake and hazard/bypass results between
// the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic             d_valid;
  logic [REG_W-1:0] d_rs1;
  logic [REG_W-1:0] d_rs2;
  logic             d_rs1_rd;
  logic             d_rs2_rd;
  logic [REG_W-1:0] d_rd;
  logic             d_we;
  logic             d_is_load;
  logic             d_is_md;
  logic             md_ready;
  logic             stall;
  logic             md_start;
  logic [1:0]       byp_a;
  logic [1:0]       byp_b;
  logic             md_err;

  modport master (
    output d_valid, d_rs1, d_rs2, d_rs1_rd, d_rs2_rd, d_rd, d_we,
           d_is_load, d_is_md, md_ready,
    input  stall, md_start, byp_a, byp_b, md_err
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_rs1_rd, d_rs2_rd, d_rd, d_we,
           d_is_load, d_is_md, md_ready,
    output stall, md_start, byp_a, byp_b, md_err
  );

endinterface

// File: rtl/hazard_ctrl_reg_match.sv
// Register dependency comparator: equal numbers, producer writes, and the
// register is not r0.
module hazard_ctrl_reg_match
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd,
  input  logic             we,
  output logic             match
);

  assign match = we && (rd != '0) && (rs == rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight destinations, raises
// load-use and multdiv stalls, and selects X-stage operand bypasses.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(MD_TIMEOUT - 1);

  state_t           state;
  dx_t              dx;
  dx_t              dx_new;
  xm_t              xm;
  mw_t              mw;
  logic [CNT_W-1:0] cnt;
  logic             md_err_q;

  logic m_lu1, m_lu2, m_xa, m_ma, m_xb, m_mb;
  logic luse, md_start, cnt_tc, md_done, stall;
  logic [1:0] byp_a, byp_b;

  always_comb begin
    dx_new        = '0;
    dx_new.v      = hif.d_valid;
    dx_new.rd     = hif.d_rd;
    dx_new.we     = hif.d_we;
    dx_new.ld     = hif.d_is_load;
    dx_new.md     = hif.d_is_md;
    dx_new.rs1    = hif.d_rs1;
    dx_new.rs2    = hif.d_rs2;
    dx_new.rs1_rd = hif.d_rs1_rd;
    dx_new.rs2_rd = hif.d_rs2_rd;
  end

  hazard_ctrl_reg_match u_lu1 (.rs(hif.d_rs1), .rd(dx.rd), .we(dx.we),         .match(m_lu1));
  hazard_ctrl_reg_match u_lu2 (.rs(hif.d_rs2), .rd(dx.rd), .we(dx.we),         .match(m_lu2));
  hazard_ctrl_reg_match u_xa  (.rs(dx.rs1),    .rd(xm.rd), .we(xm.v && xm.we), .match(m_xa));
  hazard_ctrl_reg_match u_ma  (.rs(dx.rs1),    .rd(mw.rd), .we(mw.v && mw.we), .match(m_ma));
  hazard_ctrl_reg_match u_xb  (.rs(dx.rs2),    .rd(xm.rd), .we(xm.v && xm.we), .match(m_xb));
  hazard_ctrl_reg_match u_mb  (.rs(dx.rs2),    .rd(mw.rd), .we(mw.v && mw.we), .match(m_mb));

  assign luse = (state == RUN) && hif.d_valid && dx.v && dx.ld &&
                ((hif.d_rs1_rd && m_lu1) || (hif.d_rs2_rd && m_lu2));
  assign md_start = (state == RUN) && dx.v && dx.md;
  assign cnt_tc   = (cnt == CNT_TC);
  assign md_done  = hif.md_ready || cnt_tc;
  assign stall    = luse || md_start || ((state == MD_WAIT) && !md_done);

  // Youngest producer wins; a bubble or unread source keeps the D/X value.
  always_comb begin
    byp_a = BYP_DX;
    byp_b = BYP_DX;
    if (dx.v && dx.rs1_rd) begin
      if (m_xa)      byp_a = BYP_XM;
      else if (m_ma) byp_a = BYP_MW;
    end
    if (dx.v && dx.rs2_rd) begin
      if (m_xb)      byp_b = BYP_XM;
      else if (m_mb) byp_b = BYP_MW;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      dx       <= '0;
      xm       <= '0;
      mw       <= '0;
      cnt      <= '0;
      md_err_q <= 1'b0;
    end else begin
      mw <= '{v: xm.v, rd: xm.rd, we: xm.we};
      if (state == RUN) begin
        if (md_start) begin
          state <= MD_WAIT;
          cnt   <= '0;
          xm    <= '0;
        end else begin
          xm <= '{v: dx.v, rd: dx.rd, we: dx.we};
          dx <= luse ? '0 : dx_new;
        end
      end else if (md_done) begin
        // A watchdog-released result is garbage, so it must not be forwarded.
        xm       <= '{v: dx.v, rd: dx.rd, we: dx.we && hif.md_ready};
        dx       <= dx_new;
        state    <= RUN;
        md_err_q <= md_err_q || !hif.md_ready;
      end else begin
        xm  <= '0;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign hif.stall    = stall;
  assign hif.md_start = md_start;
  assign hif.byp_a    = byp_a;
  assign hif.byp_b    = byp_b;
  assign hif.md_err   = md_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: inputs change 1 ns after the
// rising edge, outputs are checked on the falling edge.
module tb_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MD_TIMEOUT(40)) dut (
    .clock (clock),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic [4:0] rs1, input logic r1,
                       input logic [4:0] rs2, input logic r2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic md);
    hif.d_valid   = v;
    hif.d_rs1     = rs1;
    hif.d_rs1_rd  = r1;
    hif.d_rs2     = rs2;
    hif.d_rs2_rd  = r2;
    hif.d_rd      = rd;
    hif.d_we      = we;
    hif.d_is_load = ld;
    hif.d_is_md   = md;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    hif.md_ready = 1'b0;
    nop();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hif.md_ready = 1'b0;
    nop();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();
    @(negedge clock);
    total++; if (hif.stall !== 1'b0)    begin bad++; $display("FAIL rst_stall got=%0b want=0", hif.stall); end
    total++; if (hif.md_start !== 1'b0) begin bad++; $display("FAIL rst_md_start got=%0b want=0", hif.md_start); end
    total++; if (hif.byp_a !== 2'b00)   begin bad++; $display("FAIL rst_byp_a got=%b want=00", hif.byp_a); end
    total++; if (hif.byp_b !== 2'b00)   begin bad++; $display("FAIL rst_byp_b got=%b want=00", hif.byp_b); end
    total++; if (hif.md_err !== 1'b0)   begin bad++; $display("FAIL rst_md_err got=%0b want=0", hif.md_err); end
  endtask

  task automatic test_load_use();
    flush();
    drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);          // lw r5,0(r1)
    tick(); @(negedge clock);
    total++; if (hif.stall !== 1'b0) begin bad++; $display("FAIL lu_pre_stall got=%0b want=0", hif.stall); end
    tick();
    drive(1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0);          // add r6,r5,r2
    @(negedge clock);
    total++; if (hif.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", hif.stall); end
    tick(); @(negedge clock);
    total++; if (hif.stall !== 1'b0)  begin bad++; $display("FAIL lu_one_bubble got=%0b want=0", hif.stall); end
    total++; if (hif.byp_a !== 2'b00) begin bad++; $display("FAIL lu_bubble_byp got=%b want=00", hif.byp_a); end
    tick(); nop(); @(negedge clock);
    total++; if (hif.byp_a !== 2'b10) begin bad++; $display("FAIL lu_byp_a got=%b want=10", hif.byp_a); end
    total++; if (hif.byp_b !== 2'b00) begin bad++; $display("FAIL lu_byp_b got=%b want=00", hif.byp_b); end
    total++; if (hif.stall !== 1'b0)  begin bad++; $display("FAIL lu_post_stall got=%0b want=0", hif.stall); end
  endtask

  task automatic test_alu_fwd();
    flush();
    tick(); drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);  // add r3,r1,r2
    tick(); drive(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0);  // sub r4,r3,r3
    @(negedge clock);
    total++; if (hif.stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b want=0", hif.stall); end
    tick(); nop(); @(negedge clock);
    total++; if (hif.byp_a !== 2'b01) begin bad++; $display("FAIL alu_byp_a got=%b want=01", hif.byp_a); end
    total++; if (hif.byp_b !== 2'b01) begin bad++; $display("FAIL alu_byp_b got=%b want=01", hif.byp_b); end

    flush();
    tick(); drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0);  // add r0,r1,r2
    tick(); drive(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0);  // sub r4,r0,r0
    tick(); nop(); @(negedge clock);
    total++; if (hif.byp_a !== 2'b00) begin bad++; $display("FAIL r0_byp_a got=%b want=00", hif.byp_a); end
    total++; if (hif.byp_b !== 2'b00) begin bad++; $display("FAIL r0_byp_b got=%b want=00", hif.byp_b); end

    flush();
    tick(); drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);  // add r3,r1,r2
    tick(); drive(1, 5'd3, 1, 5'd1, 1, 5'd3, 1, 0, 0);  // add r3,r3,r1
    tick(); drive(1, 5'd3, 1, 5'd1, 0, 5'd4, 1, 0, 0);  // sub r4,r3 (rs2 unread)
    tick(); nop(); @(negedge clock);
    total++; if (hif.byp_a !== 2'b01) begin bad++; $display("FAIL young_byp_a got=%b want=01", hif.byp_a); end
    total++; if (hif.byp_b !== 2'b00) begin bad++; $display("FAIL unread_byp_b got=%b want=00", hif.byp_b); end

    flush();
    tick(); drive(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0);  // add r9,r1,r2
    tick(); nop();
    tick(); drive(1, 5'd1, 1, 5'd9, 1, 5'd4, 1, 0, 0);  // sub r4,r1,r9
    tick(); nop(); @(negedge clock);
    total++; if (hif.byp_a !== 2'b00) begin bad++; $display("FAIL mw_byp_a got=%b want=00", hif.byp_a); end
    total++; if (hif.byp_b !== 2'b10) begin bad++; $display("FAIL mw_byp_b got=%b want=10", hif.byp_b); end
  endtask

  task automatic test_md_ready();
    int n_stall = 0;
    int n_start = 0;
    flush();
    tick(); drive(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1);  // mul r7,r1,r2
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0);        // add r8,r7,r0
      hif.md_ready = (i == 4);
      @(negedge clock);
      if (i == 0) begin
        total++; if (hif.md_start !== 1'b1) begin bad++; $display("FAIL md_start_first got=%0b want=1", hif.md_start); end
      end
      n_stall += int'(hif.stall);
      n_start += int'(hif.md_start);
    end
    total++; if (n_stall != 4) begin bad++; $display("FAIL md_stall_cycles got=%0d want=4", n_stall); end
    total++; if (n_start != 1) begin bad++; $display("FAIL md_start_pulses got=%0d want=1", n_start); end
    tick(); hif.md_ready = 1'b0; nop(); @(negedge clock);
    total++; if (hif.byp_a !== 2'b01)   begin bad++; $display("FAIL md_byp_a got=%b want=01", hif.byp_a); end
    total++; if (hif.byp_b !== 2'b00)   begin bad++; $display("FAIL md_byp_b got=%b want=00", hif.byp_b); end
    total++; if (hif.md_start !== 1'b0) begin bad++; $display("FAIL md_no_restart got=%0b want=0", hif.md_start); end
    total++; if (hif.md_err !== 1'b0)   begin bad++; $display("FAIL md_err_clean got=%0b want=0", hif.md_err); end
  endtask

  task automatic test_md_timeout();
    int  n_stall = 0;
    bit  released = 0;
    flush();
    tick(); drive(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1);  // mul r7,r1,r2
    for (int i = 0; i < 60 && !released; i++) begin
      tick();
      drive(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0);        // add r8,r7,r0
      @(negedge clock);
      if (hif.stall === 1'b1) n_stall++;
      else released = 1;
    end
    total++; if (!released) begin bad++; $display("FAIL wd_release got=stuck want=released"); end
    total++; if (n_stall != 40) begin bad++; $display("FAIL wd_stall_cycles got=%0d want=40", n_stall); end
    total++; if (hif.md_err !== 1'b0) begin bad++; $display("FAIL wd_err_early got=%0b want=0", hif.md_err); end
    tick(); nop(); @(negedge clock);
    total++; if (hif.md_err !== 1'b1) begin bad++; $display("FAIL wd_err got=%0b want=1", hif.md_err); end
    total++; if (hif.byp_a !== 2'b00) begin bad++; $display("FAIL wd_byp_a got=%b want=00", hif.byp_a); end
    total++; if (hif.stall !== 1'b0)  begin bad++; $display("FAIL wd_stall_after got=%0b want=0", hif.stall); end
    repeat (5) tick();
    @(negedge clock);
    total++; if (hif.md_err !== 1'b1) begin bad++; $display("FAIL wd_err_sticky got=%0b want=1", hif.md_err); end
  endtask

  task automatic test_reset_in_wait();
    int n_evt = 0;
    flush();
    tick(); drive(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1);  // mul r7
    tick(); drive(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0);
    repeat (3) tick();
    @(negedge clock);
    total++; if (hif.stall !== 1'b1) begin bad++; $display("FAIL rw_wait_stall got=%0b want=1", hif.stall); end
    #1 reset = 1'b0;
    #1;
    total++; if (hif.stall !== 1'b0)    begin bad++; $display("FAIL rw_stall got=%0b want=0", hif.stall); end
    total++; if (hif.md_start !== 1'b0) begin bad++; $display("FAIL rw_md_start got=%0b want=0", hif.md_start); end
    total++; if (hif.md_err !== 1'b0)   begin bad++; $display("FAIL rw_md_err got=%0b want=0", hif.md_err); end
    total++; if (hif.byp_a !== 2'b00 || hif.byp_b !== 2'b00) begin
      bad++; $display("FAIL rw_byp got=%b/%b want=00/00", hif.byp_a, hif.byp_b);
    end
    nop();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      hif.md_ready = (i == 2);                          // stray ready in RUN
      @(negedge clock);
      n_evt += int'(hif.stall) + int'(hif.md_start);
    end
    total++; if (n_evt != 0) begin bad++; $display("FAIL rw_idle_events got=%0d want=0", n_evt); end
    tick(); hif.md_ready = 1'b0; drive(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1);
    tick(); nop(); @(negedge clock);
    total++; if (hif.md_start !== 1'b1) begin bad++; $display("FAIL rw_new_md_start got=%0b want=1", hif.md_start); end
    tick(); hif.md_ready = 1'b1; @(negedge clock);
    total++; if (hif.stall !== 1'b0) begin bad++; $display("FAIL rw_ready_stall got=%0b want=0", hif.stall); end
    tick(); hif.md_ready = 1'b0;
  endtask

  initial begin
    hif.md_ready = 1'b0;
    nop();
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_md_ready();
    test_md_timeout();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
